// File: rtl/sha2_pkg.sv
// Shared constants, types and bit-level functions for the SHA-224/256
// compression engine: round constants, both initial hash values, the FSM
// state encoding, the working-variable struct and the FIPS 180-4 functions.
package sha2_pkg;

    // Engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Eight 32-bit working variables / hash words; a (H0) is the top word
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam work_t IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam work_t IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Rotations are written as explicit slices: ROTR^n(x) = {x[n-1:0], x[31:n]}
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Word-wise mod 2^32 addition of two hash states (feed-forward step)
    function automatic work_t add_work(input work_t x, input work_t y);
        work_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One SHA-256 compression round, purely combinational. The engine chains
// RPC copies of this module to unroll several rounds per clock.
module sha2_round
    import sha2_pkg::*;
(
    input  work_t       i_work,
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output work_t       o_work
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    // T1/T2 and the register rotation a..h -> next a..h
    always_comb begin
        w_t1 = i_work.h + big_sigma1(i_work.e) + ch(i_work.e, i_work.f, i_work.g) + i_k + i_w;
        w_t2 = big_sigma0(i_work.a) + maj(i_work.a, i_work.b, i_work.c);
        o_work.a = w_t1 + w_t2;
        o_work.b = i_work.a;
        o_work.c = i_work.b;
        o_work.d = i_work.c;
        o_work.e = i_work.d + w_t1;
        o_work.f = i_work.e;
        o_work.g = i_work.f;
        o_work.h = i_work.g;
    end

endmodule

// File: rtl/sha2_block_engine.sv
// SHA-224/256 block compression engine with RPC unrolled rounds per clock.
// Accepts pre-padded 512-bit blocks framed by first/last flags, keeps the
// chaining value H across blocks and presents the digest after the last one.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid (and its payload) until that edge;
// ready never depends combinationally on valid. blk_ready is high only in
// IDLE; digest_valid with a stable digest is held until digest_ready.
module sha2_block_engine
    import sha2_pkg::*;
#(
    parameter int RPC         = 1,
    parameter bit SUPPORT_224 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         mode_224,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
        $error("sha2_block_engine: RPC must be 1, 2 or 4");
    end

    // Round index of the first round performed on the final ROUND edge
    localparam logic [5:0] LAST_T = 6'(64 - RPC);

    state_t       r_state;
    state_t       w_state_next;
    logic [5:0]   r_t;
    logic         r_last;
    logic         r_mode224;
    work_t        r_h;
    work_t        r_work;
    logic [31:0]  r_w [16];
    logic [255:0] r_digest;
    logic         r_digest_valid;

    logic         w_accept;
    logic         w_mode_in;
    work_t        w_iv;
    work_t        w_h_base;
    work_t        w_h_next;
    work_t        w_round_out;
    logic [31:0]  w_win_out [16];
    logic [255:0] w_digest_fmt;

    // IV selection; without 224 support the mode input is ignored entirely
    if (SUPPORT_224) begin : g_iv_224
        assign w_iv      = mode_224 ? IV_224 : IV_256;
        assign w_mode_in = mode_224;
    end else begin : g_iv_256
        assign w_iv      = IV_256;
        assign w_mode_in = 1'b0;
    end

    assign w_accept     = blk_valid & (r_state == ST_IDLE);
    assign w_h_base     = blk_first ? w_iv : r_h;
    assign w_h_next     = add_work(r_h, r_work);
    assign w_digest_fmt = r_mode224 ? {w_h_next[255:32], 32'h0} : w_h_next;

    // RPC chained rounds; each stage also slides the schedule window by one
    // word. Stage j consumes window word 0 as W[t+j] and appends W[t+j+16].
    for (genvar j = 0; j < RPC; j++) begin : g_stage
        work_t       w_in;
        work_t       w_out;
        logic [31:0] w_win_in  [16];
        logic [31:0] w_win_out [16];
        logic [31:0] w_k;

        if (j == 0) begin : g_head
            assign w_in     = r_work;
            assign w_win_in = r_w;
        end else begin : g_chain
            assign w_in     = g_stage[j-1].w_out;
            assign w_win_in = g_stage[j-1].w_win_out;
        end

        assign w_k = K[r_t + 6'(j)];

        // Shift the 16-word window and append the next expanded word
        always_comb begin
            for (int i = 0; i < 15; i++) begin
                w_win_out[i] = w_win_in[i+1];
            end
            w_win_out[15] = small_sigma1(w_win_in[14]) + w_win_in[9]
                          + small_sigma0(w_win_in[1]) + w_win_in[0];
        end

        sha2_round u_round (
            .i_work (w_in),
            .i_k    (w_k),
            .i_w    (w_win_in[0]),
            .o_work (w_out)
        );
    end

    assign w_round_out = g_stage[RPC-1].w_out;
    assign w_win_out   = g_stage[RPC-1].w_win_out;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        blk_ready    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (blk_valid) begin
                    w_state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (r_t == LAST_T) begin
                    w_state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_state_next = r_last ? ST_OUT : ST_IDLE;
            end
            ST_OUT: begin
                if (digest_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Round counter, last-block flag and message mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t       <= 6'd0;
            r_last    <= 1'b0;
            r_mode224 <= 1'b0;
        end else if (w_accept) begin
            r_t    <= 6'd0;
            r_last <= blk_last;
            if (blk_first) begin
                r_mode224 <= w_mode_in;
            end
        end else if (r_state == ST_ROUND) begin
            r_t <= r_t + 6'(RPC);
        end
    end

    // Chaining value: base loaded at block accept, feed-forward at FINAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= IV_256;
        end else if (w_accept) begin
            r_h <= w_h_base;
        end else if (r_state == ST_FINAL) begin
            r_h <= w_h_next;
        end
    end

    // Working variables and schedule window; contents are don't-care at reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_work <= w_h_base;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= blk_data[511 - 32*i -: 32];
            end
        end else if (r_state == ST_ROUND) begin
            r_work <= w_round_out;
            r_w    <= w_win_out;
        end
    end

    // Digest register: loaded after the last block, kept after the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digest       <= 256'h0;
            r_digest_valid <= 1'b0;
        end else if (r_state == ST_FINAL && r_last) begin
            r_digest       <= w_digest_fmt;
            r_digest_valid <= 1'b1;
        end else if (r_state == ST_OUT && digest_ready) begin
            r_digest_valid <= 1'b0;
        end
    end

    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha2_block_engine.sv
// Bench for sha2_block_engine: three instances (RPC=1 with 224 support,
// RPC=2 without it, RPC=4) checked against known FIPS 180-4 digests via an
// expected-digest queue.
module tb_sha2_block_engine;

    localparam logic [511:0] MSG_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] MSG_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] MSG_TWO_1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] MSG_TWO_2 = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_224   = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam int RPC_OF [3] = '{1, 2, 4};

    logic         clk;
    logic         rst_n;
    logic         blk_valid    [3];
    logic         blk_ready    [3];
    logic [511:0] blk_data     [3];
    logic         blk_first    [3];
    logic         blk_last     [3];
    logic         mode_224     [3];
    logic         digest_valid [3];
    logic         digest_ready [3];
    logic [255:0] digest       [3];
    logic         busy         [3];

    logic [255:0] exp_q [$];
    int           n_checks;
    int           n_fail;

    sha2_block_engine #(.RPC(1), .SUPPORT_224(1'b1)) u_dut_r1 (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_data(blk_data[0]),
        .blk_first(blk_first[0]), .blk_last(blk_last[0]), .mode_224(mode_224[0]),
        .digest_valid(digest_valid[0]), .digest_ready(digest_ready[0]),
        .digest(digest[0]), .busy(busy[0])
    );

    sha2_block_engine #(.RPC(2), .SUPPORT_224(1'b0)) u_dut_r2 (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_data(blk_data[1]),
        .blk_first(blk_first[1]), .blk_last(blk_last[1]), .mode_224(mode_224[1]),
        .digest_valid(digest_valid[1]), .digest_ready(digest_ready[1]),
        .digest(digest[1]), .busy(busy[1])
    );

    sha2_block_engine #(.RPC(4), .SUPPORT_224(1'b1)) u_dut_r4 (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid[2]), .blk_ready(blk_ready[2]), .blk_data(blk_data[2]),
        .blk_first(blk_first[2]), .blk_last(blk_last[2]), .mode_224(mode_224[2]),
        .digest_valid(digest_valid[2]), .digest_ready(digest_ready[2]),
        .digest(digest[2]), .busy(busy[2])
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one block and return #1 after the accepting edge
    task automatic send_block(input int idx, input logic [511:0] data, input logic first,
                              input logic last, input logic m224, input logic [255:0] exp);
        int waited;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        blk_data[idx]  = data;
        blk_first[idx] = first;
        blk_last[idx]  = last;
        mode_224[idx]  = m224;
        blk_valid[idx] = 1'b1;
        waited = 0;
        while (!blk_ready[idx] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept_in_time", 256'(waited < 200), 256'(1));
        @(posedge clk);
        #1;
        blk_valid[idx] = 1'b0;
        if (last) exp_q.push_back(exp);
    endtask

    // After a non-last block: ready returns with no digest in between
    task automatic wait_block_done(input int idx);
        int   cyc;
        logic saw;
        cyc = 0;
        saw = 1'b0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
            if (digest_valid[idx]) saw = 1'b1;
        end while (!blk_ready[idx] && cyc < 200);
        check_eq("midmsg_ready_latency", 256'(cyc), 256'(64 / RPC_OF[idx] + 1));
        check_eq("midmsg_no_digest", 256'(saw), 256'(0));
    endtask

    // Wait for the digest, compare against the queue, optionally stall the consumer
    task automatic wait_digest(input int idx, input int hold);
        int           cyc;
        logic [255:0] exp;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!digest_valid[idx] && cyc < 200);
        check_eq("digest_latency", 256'(cyc), 256'(64 / RPC_OF[idx] + 1));
        check_eq("exp_q_nonempty", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else exp = '0;
        check_eq("digest_value", digest[idx], exp);
        check_eq("blk_ready_in_out", 256'(blk_ready[idx]), 256'(0));
        if (hold > 0) begin
            blk_data[idx]  = MSG_EMPTY;
            blk_first[idx] = 1'b1;
            blk_last[idx]  = 1'b1;
            blk_valid[idx] = 1'b1;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq("hold_valid", 256'(digest_valid[idx]), 256'(1));
            check_eq("hold_digest", digest[idx], exp);
            check_eq("hold_blk_ready", 256'(blk_ready[idx]), 256'(0));
        end
        @(negedge clk);
        blk_valid[idx]    = 1'b0;
        digest_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        digest_ready[idx] = 1'b0;
        check_eq("release_valid_low", 256'(digest_valid[idx]), 256'(0));
        check_eq("digest_retained", digest[idx], exp);
        @(negedge clk);
        check_eq("idle_after_release", 256'(busy[idx]), 256'(0));
    endtask

    task automatic check_reset_state(input int idx);
        check_eq("rst_blk_ready", 256'(blk_ready[idx]), 256'(1));
        check_eq("rst_digest_valid", 256'(digest_valid[idx]), 256'(0));
        check_eq("rst_digest", digest[idx], 256'h0);
        check_eq("rst_busy", 256'(busy[idx]), 256'(0));
    endtask

    // Stimulus sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            blk_valid[i]    = 1'b0;
            blk_data[i]     = '0;
            blk_first[i]    = 1'b0;
            blk_last[i]     = 1'b0;
            mode_224[i]     = 1'b0;
            digest_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset_state(i);
        @(negedge clk);
        rst_n = 1'b1;

        // SHA-256 "abc", RPC=1
        send_block(0, MSG_ABC, 1'b1, 1'b1, 1'b0, DIG_ABC);
        wait_digest(0, 0);

        // SHA-224 "abc"
        send_block(0, MSG_ABC, 1'b1, 1'b1, 1'b1, DIG_224);
        wait_digest(0, 0);

        // Two-block message back in 256 mode
        send_block(0, MSG_TWO_1, 1'b1, 1'b0, 1'b0, '0);
        wait_block_done(0);
        send_block(0, MSG_TWO_2, 1'b0, 1'b1, 1'b0, DIG_TWO);
        wait_digest(0, 0);

        // Empty message, RPC=4 and RPC=2
        send_block(2, MSG_EMPTY, 1'b1, 1'b1, 1'b0, DIG_EMPTY);
        wait_digest(2, 0);
        send_block(1, MSG_EMPTY, 1'b1, 1'b1, 1'b0, DIG_EMPTY);
        wait_digest(1, 0);

        // mode_224 ignored when 224 support is absent
        send_block(1, MSG_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
        wait_digest(1, 0);

        // Two-block message with four rounds per clock
        send_block(2, MSG_TWO_1, 1'b1, 1'b0, 1'b0, '0);
        wait_block_done(2);
        send_block(2, MSG_TWO_2, 1'b0, 1'b1, 1'b0, DIG_TWO);
        wait_digest(2, 0);

        // Consumer backpressure for 10 cycles, then a fresh message
        send_block(0, MSG_ABC, 1'b1, 1'b1, 1'b0, DIG_ABC);
        wait_digest(0, 10);
        send_block(0, MSG_ABC, 1'b1, 1'b1, 1'b0, DIG_ABC);
        wait_digest(0, 0);

        // Reset in the middle of round processing
        send_block(0, MSG_ABC, 1'b1, 1'b1, 1'b0, DIG_ABC);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state(0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // First block after reset without blk_first chains from the SHA-256 IV
        send_block(0, MSG_ABC, 1'b0, 1'b1, 1'b1, DIG_ABC);
        wait_digest(0, 0);

        check_eq("exp_q_drained", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
